// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider.
//   - divider FSM state encoding
//   - default operand width and the matching iteration-counter width
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/seq_divider_cla_subtractor.sv
// N-bit subtractor diff = a + ~b + 1 built from chained 8-bit carry-lookahead
// slices.
//   a, b : N-bit operands (N-1 must be a multiple of 8)
//   diff : N-bit result
// The operands the divider feeds in are always below 2^(N-1), so diff[N-1]
// is set exactly when a < b (the borrow).
module eight_bit_cla (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] gen_s;
  logic [7:0] prop_s;
  logic [8:0] carry_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Carry recurrence over generate/propagate terms; flattens to lookahead logic.
  always_comb begin
    carry_s    = 9'd0;
    carry_s[0] = cin;
    for (int i = 0; i < 8; i++) begin
      carry_s[i+1] = gen_s[i] | (prop_s[i] & carry_s[i]);
    end
  end

  assign sum  = prop_s ^ carry_s[7:0];
  assign cout = carry_s[8];

endmodule

module cla_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff
);

  localparam int SLICES = (N - 1) / 8;

  logic [N-1:0]    b_inv_s;
  logic [SLICES:0] chain_s;

  assign b_inv_s    = ~b;
  assign chain_s[0] = 1'b1;

  for (genvar g = 0; g < SLICES; g++) begin : g_slice
    eight_bit_cla u_cla (
      .a    (a[8*g+7:8*g]),
      .b    (b_inv_s[8*g+7:8*g]),
      .cin  (chain_s[g]),
      .sum  (diff[8*g+7:8*g]),
      .cout (chain_s[g+1])
    );
  end

  // The single top bit past the last slice only needs its sum, not a carry.
  assign diff[N-1] = a[N-1] ^ b_inv_s[N-1] ^ chain_s[SLICES];

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider.
//   clock, reset_n      : clock, synchronous active-low reset
//   ctrl_div            : start strobe, honoured only in IDLE
//   dividend, divisor   : signed operands captured with the start strobe
//   quotient, remainder : signed results (remainder takes the dividend's sign)
//   exception           : divide-by-zero or most-negative / -1 overflow
//   result_ready        : one-cycle pulse when the results are valid
//   busy                : high while a division is in flight
// One trial subtraction per cycle for WIDTH cycles, one fix-up cycle that
// applies the signs, then the DONE cycle that raises result_ready.
import seq_divider_pkg::*;

module seq_divider #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             result_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  div_state_t state_r;
  div_state_t next_s;

  logic [CW-1:0]    count_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH:0]   den_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             ovf_r;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             exception_r;
  logic             result_ready_r;
  logic             busy_r;

  logic             start_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] quo_sh_s;
  logic [WIDTH:0]   sub_a_s;
  logic [WIDTH:0]   sub_b_s;
  logic [WIDTH:0]   sub_diff_s;
  logic [WIDTH:0]   negq_diff_s;

  assign start_s    = (state_r == ST_IDLE) && ctrl_div;
  assign div_zero_s = (divisor == {WIDTH{1'b0}});
  assign ovf_s      = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (divisor == {WIDTH{1'b1}});

  // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1) exactly.
  assign dvd_mag_s = dividend[WIDTH-1] ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
  assign dvs_mag_s = divisor[WIDTH-1]  ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;

  // {R,Q} shifted left by one; the new quotient bit is filled in after the trial.
  assign rem_sh_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
  assign quo_sh_s = {quo_r[WIDTH-2:0], 1'b0};

  // Shared subtractor: trial subtraction while running, 0 - R in the fix-up cycle.
  always_comb begin
    sub_a_s = {(WIDTH+1){1'b0}};
    sub_b_s = {(WIDTH+1){1'b0}};
    if (state_r == ST_FIX) begin
      sub_a_s = {(WIDTH+1){1'b0}};
      sub_b_s = rem_r;
    end else begin
      sub_a_s = rem_sh_s;
      sub_b_s = den_r;
    end
  end

  cla_subtractor #(.N(WIDTH+1)) u_sub (
    .a    (sub_a_s),
    .b    (sub_b_s),
    .diff (sub_diff_s)
  );

  // Quotient negation; its top bit doubles as a "quotient is non-zero" flag.
  cla_subtractor #(.N(WIDTH+1)) u_negq (
    .a    ({(WIDTH+1){1'b0}}),
    .b    ({1'b0, quo_r}),
    .diff (negq_diff_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_div) begin
          if (div_zero_s) begin
            next_s = ST_DONE;
          end else begin
            next_s = ST_RUN;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_r == CW'(WIDTH - 1)) begin
          next_s = ST_FIX;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_FIX:  next_s = ST_DONE;
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Iteration datapath: operand capture and one restoring step per RUN cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_r <= {CW{1'b0}};
      rem_r   <= {(WIDTH+1){1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      den_r   <= {(WIDTH+1){1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (start_s) begin
      count_r <= {CW{1'b0}};
      rem_r   <= {(WIDTH+1){1'b0}};
      quo_r   <= dvd_mag_s;
      den_r   <= {1'b0, dvs_mag_s};
      q_neg_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
      ovf_r   <= ovf_s;
    end else if (state_r == ST_RUN) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      // Top bit of the trial result is the borrow: set means R < D, restore.
      if (sub_diff_s[WIDTH]) begin
        rem_r <= rem_sh_s;
        quo_r <= quo_sh_s;
      end else begin
        rem_r <= sub_diff_s;
        quo_r <= {quo_sh_s[WIDTH-1:1], 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Output registers: results, exception flag, ready pulse and busy.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      quotient_r     <= {WIDTH{1'b0}};
      remainder_r    <= {WIDTH{1'b0}};
      exception_r    <= 1'b0;
      result_ready_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      result_ready_r <= (next_s == ST_DONE);
      busy_r         <= (next_s == ST_RUN) || (next_s == ST_FIX);
      if (start_s) begin
        if (div_zero_s) begin
          quotient_r  <= {WIDTH{1'b0}};
          remainder_r <= {WIDTH{1'b0}};
          exception_r <= 1'b1;
        end else begin
          exception_r <= 1'b0;
        end
      end else if (state_r == ST_FIX) begin
        quotient_r  <= (q_neg_r && negq_diff_s[WIDTH]) ? negq_diff_s[WIDTH-1:0] : quo_r;
        remainder_r <= r_neg_r ? sub_diff_s[WIDTH-1:0] : rem_r[WIDTH-1:0];
        exception_r <= ovf_r;
      end else begin
        exception_r <= exception_r;
      end
    end
  end

  assign quotient     = quotient_r;
  assign remainder    = remainder_r;
  assign exception    = exception_r;
  assign result_ready = result_ready_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a table of signed divisions with
// hand-computed results and latencies, plus sequences for reset, ignored
// starts and start strobes during the DONE cycle.
module tb_seq_divider;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic         ctrl_div;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         exception;
  logic         result_ready;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ctrl_div     (ctrl_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .exception    (exception),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one division from IDLE and wait (bounded) for result_ready.
  // Returns in the result_ready cycle, 1 time unit after the edge.
  task automatic do_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        output int lat, output logic busy1);
    @(posedge clock); #1;
    dividend = dvd;
    divisor  = dvs;
    ctrl_div = 1'b1;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    lat   = 1;
    busy1 = busy;
    while (!result_ready && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic busy1;
    int   pulses;
    int   first;
    logic [W-1:0] q_seen;
    logic [W-1:0] r_seen;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 34};
    vecs[2]  = '{32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 1};
    vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1, 34};
    vecs[4]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 34};
    vecs[5]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 34};
    vecs[6]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 34};
    vecs[7]  = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 34};
    vecs[8]  = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 34};
    vecs[9]  = '{32'hFFFFFFFF,   32'h80000000,   32'd0,          32'hFFFFFFFF,   1'b0, 34};
    vecs[10] = '{32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0, 34};
    vecs[11] = '{32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0, 34};

    reset_n  = 1'b0;
    ctrl_div = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset quotient",     quotient,            32'd0);
    check("reset remainder",    remainder,           32'd0);
    check("reset exception",    {31'd0, exception},    32'd0);
    check("reset result_ready", {31'd0, result_ready}, 32'd0);
    check("reset busy",         {31'd0, busy},         32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_div(vecs[i].dvd, vecs[i].dvs, lat, busy1);
      check($sformatf("v%0d latency", i),   32'(lat),             32'(vecs[i].lat));
      check($sformatf("v%0d quotient", i),  quotient,             vecs[i].q);
      check($sformatf("v%0d remainder", i), remainder,            vecs[i].r);
      check($sformatf("v%0d exception", i), {31'd0, exception},   {31'd0, vecs[i].e});
      check($sformatf("v%0d busy done", i), {31'd0, busy},        32'd0);
      check($sformatf("v%0d busy c1", i),   {31'd0, busy1},       (vecs[i].lat > 1) ? 32'd1 : 32'd0);
    end

    // Start strobe during the DONE cycle (div-by-zero operands) must be ignored.
    dividend = 32'd9;
    divisor  = 32'd0;
    ctrl_div = 1'b1;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    check("done-start rr idle", {31'd0, result_ready}, 32'd0);
    @(posedge clock); #1;
    check("done-start rr next", {31'd0, result_ready}, 32'd0);
    check("done-start busy",    {31'd0, busy},         32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("hold quotient",  quotient,  32'd1);
    check("hold remainder", remainder, 32'd0);

    // Start 100/7, then strobe 9/3 in cycle 10: one result, 14 r 2, at cycle 34.
    @(posedge clock); #1;
    dividend = 32'd100;
    divisor  = 32'd7;
    ctrl_div = 1'b1;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    pulses = 0;
    first  = 0;
    q_seen = '0;
    r_seen = '0;
    for (int n = 1; n <= 60; n++) begin
      if (result_ready) begin
        pulses++;
        if (first == 0) begin
          first  = n;
          q_seen = quotient;
          r_seen = remainder;
        end
      end
      if (n == 10) begin
        dividend = 32'd9;
        divisor  = 32'd3;
        ctrl_div = 1'b1;
      end
      if (n == 11) ctrl_div = 1'b0;
      @(posedge clock); #1;
    end
    check("ignored-start pulses",    32'(pulses), 32'd1);
    check("ignored-start latency",   32'(first),  32'd34);
    check("ignored-start quotient",  q_seen,      32'd14);
    check("ignored-start remainder", r_seen,      32'd2);

    // Start 100/7, reset in cycle 15: outputs cleared and no result pulse.
    dividend = 32'd100;
    divisor  = 32'd7;
    ctrl_div = 1'b1;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    for (int n = 1; n < 15; n++) begin
      @(posedge clock); #1;
    end
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("abort quotient",     quotient,               32'd0);
    check("abort remainder",    remainder,              32'd0);
    check("abort exception",    {31'd0, exception},     32'd0);
    check("abort busy",         {31'd0, busy},          32'd0);
    check("abort result_ready", {31'd0, result_ready},  32'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (result_ready) pulses++;
    end
    check("abort no pulse", 32'(pulses), 32'd0);

    do_div(32'd9, 32'd3, lat, busy1);
    check("after-abort latency",   32'(lat),            32'd34);
    check("after-abort quotient",  quotient,            32'd3);
    check("after-abort remainder", remainder,           32'd0);
    check("after-abort exception", {31'd0, exception},  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
